// File: rtl/fifo_unpack_if.sv
// Bundle of the FIFO read port and the narrow valid/ready output stream seen by fifo_unpack.
// The master side is the unpacker; the slave side is the surrounding FIFO and consumer.
interface fifo_unpack_if #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8
);
    logic                 fifo_empty;
    logic                 fifo_rd;
    logic [IN_WIDTH-1:0]  fifo_dout;
    logic                 m_valid;
    logic                 m_ready;
    logic [OUT_WIDTH-1:0] m_data;
    logic                 m_last;

    modport master (
        input  fifo_empty, fifo_dout, m_ready,
        output fifo_rd, m_valid, m_data, m_last
    );

    modport slave (
        output fifo_empty, fifo_dout, m_ready,
        input  fifo_rd, m_valid, m_data, m_last
    );
endinterface

// File: rtl/fifo_unpack.sv
// Width down-converter: pops wide words from a first-word-fall-through FIFO and emits
// them as IN_WIDTH/OUT_WIDTH narrow beats, one per cycle, with no bubble between words.
module fifo_unpack #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    fifo_unpack_if.master bus
);
    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;

    generate
        if (RATIO < 2 || (IN_WIDTH % OUT_WIDTH) != 0) begin : g_bad_ratio
            $error("fifo_unpack: IN_WIDTH must be an integer multiple (>=2) of OUT_WIDTH");
        end
    endgenerate

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t               state_q, state_d;
    logic [IN_WIDTH-1:0]  word_q, word_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CW-1:0]        sel;
    logic                 loaded;
    logic                 at_last;
    logic                 take;
    logic                 pop;
    logic [OUT_WIDTH-1:0] slice [RATIO];

    assign loaded  = (state_q == SHIFT);
    assign at_last = (cnt_q == CW'(RATIO - 1));
    assign take    = loaded & bus.m_ready;

    // Refill on the last-beat handshake so the next word's beat 0 follows with no gap.
    assign pop = ~rst & ~bus.fifo_empty & (~loaded | (take & at_last));

    assign bus.fifo_rd = pop;
    assign bus.m_valid = loaded;
    assign bus.m_last  = at_last & loaded;

    for (genvar i = 0; i < RATIO; i++) begin : g_slice
        assign slice[i] = word_q[i*OUT_WIDTH +: OUT_WIDTH];
    end

    assign sel        = LSB_FIRST ? cnt_q : (CW'(RATIO - 1) - cnt_q);
    assign bus.m_data = slice[sel];

    // NOTE: every signal gets its hold value before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    word_d  = bus.fifo_dout;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (take) begin
                    if (!at_last) begin
                        cnt_d = cnt_q + 1'b1;
                    end else if (pop) begin
                        word_d = bus.fifo_dout;
                        cnt_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the data register is reset too, because m_data must read zero while rst is high.
    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_fifo_unpack.sv
// Self-checking bench for fifo_unpack: LSB-first and MSB-first instances, each fed by a
// small FWFT FIFO model, with a scoreboard of expected beats filled as words are pushed.
module tb_fifo_unpack;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fifo_unpack_if #(.IN_WIDTH(32), .OUT_WIDTH(8)) if1 ();
    fifo_unpack_if #(.IN_WIDTH(32), .OUT_WIDTH(8)) if2 ();

    fifo_unpack #(.IN_WIDTH(32), .OUT_WIDTH(8), .LSB_FIRST(1'b1)) dut_lsb (
        .clk (clk),
        .rst (rst),
        .bus (if1.master)
    );

    fifo_unpack #(.IN_WIDTH(32), .OUT_WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
        .clk (clk),
        .rst (rst),
        .bus (if2.master)
    );

    int checks = 0;
    int errors = 0;

    // FWFT FIFO models
    logic [31:0] mem1 [16];
    logic [31:0] mem2 [16];
    int wr1 = 0, rd1 = 0, wr2 = 0, rd2 = 0;

    assign if1.fifo_empty = (wr1 == rd1);
    assign if1.fifo_dout  = mem1[rd1[3:0]];
    assign if2.fifo_empty = (wr2 == rd2);
    assign if2.fifo_dout  = mem2[rd2[3:0]];

    always @(posedge clk) if (if1.fifo_rd) rd1 <= rd1 + 1;
    always @(posedge clk) if (if2.fifo_rd) rd2 <= rd2 + 1;

    // Scoreboard entries are {last, data}
    logic [8:0] exp1 [$];
    logic [8:0] exp2 [$];
    int hs1 = 0, hs2 = 0;

    task automatic push1(input logic [31:0] w);
        mem1[wr1[3:0]] = w;
        wr1++;
        for (int i = 0; i < 4; i++) exp1.push_back({i == 3, w[8*i +: 8]});
    endtask

    task automatic push2(input logic [31:0] w);
        mem2[wr2[3:0]] = w;
        wr2++;
        for (int i = 0; i < 4; i++) exp2.push_back({i == 3, w[8*(3-i) +: 8]});
    endtask

    task automatic monitor1();
        logic       stall = 1'b0;
        logic [7:0] hold_data = '0;
        logic       hold_last = 1'b0;
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (if1.fifo_rd === 1'b1) begin
                checks++;
                if (if1.fifo_empty !== 1'b0) begin
                    errors++;
                    $display("FAIL rd_while_empty: fifo_rd=1 with fifo_empty=%b, required empty=0", if1.fifo_empty);
                end
            end
            if (stall && !rst) begin
                checks++;
                if (if1.m_valid !== 1'b1 || if1.m_data !== hold_data || if1.m_last !== hold_last) begin
                    errors++;
                    $display("FAIL hold_stable: got valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                             if1.m_valid, if1.m_data, if1.m_last, hold_data, hold_last);
                end
            end
            if (if1.m_valid === 1'b1 && if1.m_ready === 1'b1) begin
                hs1++;
                checks++;
                if (exp1.size() == 0) begin
                    errors++;
                    $display("FAIL lsb_beat: unexpected beat data=%h last=%b, required none", if1.m_data, if1.m_last);
                end else begin
                    e = exp1.pop_front();
                    if ({if1.m_last, if1.m_data} !== e) begin
                        errors++;
                        $display("FAIL lsb_beat: got data=%h last=%b, required data=%h last=%b",
                                 if1.m_data, if1.m_last, e[7:0], e[8]);
                    end
                end
            end
            stall     = (if1.m_valid === 1'b1) && (if1.m_ready !== 1'b1) && !rst;
            hold_data = if1.m_data;
            hold_last = if1.m_last;
        end
    endtask

    task automatic monitor2();
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (if2.m_valid === 1'b1 && if2.m_ready === 1'b1) begin
                hs2++;
                checks++;
                if (exp2.size() == 0) begin
                    errors++;
                    $display("FAIL msb_beat: unexpected beat data=%h last=%b, required none", if2.m_data, if2.m_last);
                end else begin
                    e = exp2.pop_front();
                    if ({if2.m_last, if2.m_data} !== e) begin
                        errors++;
                        $display("FAIL msb_beat: got data=%h last=%b, required data=%h last=%b",
                                 if2.m_data, if2.m_last, e[7:0], e[8]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({if1.m_valid, if1.m_last, if1.m_data, if1.fifo_rd} !== 11'h0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b last=%b data=%h rd=%b, required all 0",
                     if1.m_valid, if1.m_last, if1.m_data, if1.fifo_rd);
        end
        checks++;
        if ({if2.m_valid, if2.m_last, if2.m_data} !== 10'h0) begin
            errors++;
            $display("FAIL reset_outputs_msb: got valid=%b last=%b data=%h, required all 0",
                     if2.m_valid, if2.m_last, if2.m_data);
        end
        repeat (2) @(posedge clk);
        #1 push1(32'hCAFEF00D);
        #1;
        checks++;
        if (if1.fifo_rd !== 1'b0) begin
            errors++;
            $display("FAIL rd_in_reset: got fifo_rd=%b, required 0", if1.fifo_rd);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        if1.m_ready = 1'b1;
        #1;
        checks++;
        if (if1.fifo_rd !== 1'b1) begin
            errors++;
            $display("FAIL first_pop: got fifo_rd=%b, required 1 right after reset release", if1.fifo_rd);
        end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (exp1.size() != 0) begin
            errors++;
            $display("FAIL post_reset_word: got %0d beats outstanding, required 0", exp1.size());
        end
    endtask

    task automatic test_single();
        int base;
        @(posedge clk);
        #1 base = hs1;
        push1(32'hAABBCCDD);
        @(negedge clk);
        checks++;
        if (if1.fifo_rd !== 1'b1 || if1.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pop: got rd=%b valid=%b, required rd=1 valid=0", if1.fifo_rd, if1.m_valid);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (if1.m_valid !== 1'b1 || if1.m_last !== (i == 3)) begin
                errors++;
                $display("FAIL single_beat%0d: got valid=%b last=%b, required valid=1 last=%b",
                         i, if1.m_valid, if1.m_last, i == 3);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (if1.m_valid !== 1'b0 || hs1 - base != 4) begin
            errors++;
            $display("FAIL single_end: got valid=%b handshakes=%0d, required valid=0 handshakes=4",
                     if1.m_valid, hs1 - base);
        end
    endtask

    task automatic test_back_to_back();
        @(posedge clk);
        #1 push1(32'h03020100);
        push1(32'h07060504);
        @(negedge clk);
        checks++;
        if (if1.fifo_rd !== 1'b1 || if1.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_pop: got rd=%b valid=%b, required rd=1 valid=0", if1.fifo_rd, if1.m_valid);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (if1.m_valid !== 1'b1 || if1.fifo_rd !== (i == 3)) begin
                errors++;
                $display("FAIL b2b_beat%0d: got valid=%b rd=%b, required valid=1 rd=%b",
                         i, if1.m_valid, if1.fifo_rd, i == 3);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (if1.m_valid !== 1'b0 || exp1.size() != 0) begin
            errors++;
            $display("FAIL b2b_end: got valid=%b outstanding=%0d, required valid=0 outstanding=0",
                     if1.m_valid, exp1.size());
        end
    endtask

    task automatic test_backpressure();
        logic [6:0] pat = 7'b1011001;
        int base;
        @(posedge clk);
        #1 base = hs1;
        push1(32'h44332211);
        @(posedge clk);
        #1;
        for (int i = 0; i < 7; i++) begin
            if1.m_ready = pat[i];
            @(posedge clk);
            #1;
        end
        checks++;
        if (if1.m_valid !== 1'b0 || hs1 - base != 4) begin
            errors++;
            $display("FAIL backpressure: got valid=%b handshakes=%0d, required valid=0 handshakes=4",
                     if1.m_valid, hs1 - base);
        end
        if1.m_ready = 1'b1;
    endtask

    task automatic test_msb_first();
        int base;
        @(posedge clk);
        #1 base = hs2;
        if2.m_ready = 1'b1;
        push2(32'hAABBCCDD);
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (hs2 - base != 4 || exp2.size() != 0 || if2.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL msb_first: got handshakes=%0d outstanding=%0d valid=%b, required 4 0 0",
                     hs2 - base, exp2.size(), if2.m_valid);
        end
    endtask

    task automatic test_empty();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (if1.fifo_rd !== 1'b0 || if1.m_valid !== 1'b0) begin
                errors++;
                $display("FAIL empty_idle%0d: got rd=%b valid=%b, required 0 0", i, if1.fifo_rd, if1.m_valid);
            end
        end
    endtask

    task automatic test_reset_mid_word();
        int base;
        @(posedge clk);
        #1 push1(32'h44332211);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (if1.m_valid !== 1'b0 || if1.fifo_rd !== 1'b0 || if1.m_last !== 1'b0 || if1.m_data !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got valid=%b rd=%b last=%b data=%h, required all 0",
                     if1.m_valid, if1.fifo_rd, if1.m_last, if1.m_data);
        end
        checks++;
        if (exp1.size() != 3) begin
            errors++;
            $display("FAIL reset_discard: got %0d beats outstanding, required 3 (22,33,44)", exp1.size());
        end
        exp1.delete();
        repeat (2) @(posedge clk);
        #1 base = hs1;
        push1(32'h88776655);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (hs1 - base != 4 || exp1.size() != 0 || if1.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_word: got handshakes=%0d outstanding=%0d valid=%b, required 4 0 0",
                     hs1 - base, exp1.size(), if1.m_valid);
        end
    endtask

    initial begin
        rst         = 1'b1;
        if1.m_ready = 1'b0;
        if2.m_ready = 1'b0;
        fork
            monitor1();
            monitor2();
        join_none
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_msb_first();
        test_empty();
        test_reset_mid_word();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (exp1.size() != 0 || exp2.size() != 0) begin
            errors++;
            $display("FAIL drained: got outstanding lsb=%0d msb=%0d, required 0 0", exp1.size(), exp2.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
